// File: rtl/rr_arb4_2x.sv
// rr_arb4_2x: four-requester round-robin arbiter with registered, non-preemptive grants.
//
// Ports
//   CLK     in   clock, all state on rising edge
//   RSTB    in   asynchronous active-low reset
//   REQ     in   [3:0] level requests, REQ[i] for requester i
//   DONE    in   current owner releases the grant (ignored while idle)
//   GNT     out  [3:0] registered one-hot grant, or zero
//   GNT_ID  out  [1:0] registered owner index, 0 when idle
//   BUSY    out  registered, high while a grant is held
//   TMO     out  registered one-cycle forced-release pulse
//
// Parameter
//   TMO_CYC 4-bit maximum grant hold in cycles (1..15); only used with the timeout option.
//
// Configuration macro
//   RR_ARB4_TMO_EN  when defined, adds a hold counter that forces release after TMO_CYC
//                   grant cycles and pulses TMO. When undefined, TMO is tied low and a
//                   grant is held until DONE or the owner drops its request.
//
// Every release returns to IDLE for at least one cycle, so grants are never back-to-back.
module rr_arb4_2x #(
  parameter logic [3:0] TMO_CYC = 4'd15
) (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic [3:0] REQ,
  input  logic       DONE,
  output logic [3:0] GNT,
  output logic [1:0] GNT_ID,
  output logic       BUSY,
  output logic       TMO
);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e     r_state;
  logic [1:0] r_ptr;
  logic [3:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic       r_busy;

  logic [1:0] w_pick;
  logic [1:0] w_idx;
  logic       w_release;

  // Rotating priority search starting at r_ptr. Scanning from the farthest
  // offset back to offset 0 lets the closest set request win.
  always_comb begin
    w_pick = 2'd0;
    w_idx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (REQ[w_idx]) begin
        w_pick = w_idx;
      end
    end
  end

  // Normal release: explicit DONE or the owner withdrew its request.
  assign w_release = DONE | ~REQ[r_gnt_id];

`ifdef RR_ARB4_TMO_EN
  logic [3:0] r_cnt;
  logic       r_tmo;
  logic [3:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state  <= StIdle;
      r_ptr    <= 2'd0;
      r_gnt    <= 4'b0000;
      r_gnt_id <= 2'd0;
      r_busy   <= 1'b0;
      r_cnt    <= 4'd0;
      r_tmo    <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        StIdle: begin
          if (|REQ) begin
            r_state  <= StGrant;
            r_gnt    <= 4'b0001 << w_pick;
            r_gnt_id <= w_pick;
            r_busy   <= 1'b1;
            r_ptr    <= w_pick + 2'd1;
            r_cnt    <= 4'd0;
          end
        end
        StGrant: begin
          if (w_release) begin
            r_state  <= StIdle;
            r_gnt    <= 4'b0000;
            r_gnt_id <= 2'd0;
            r_busy   <= 1'b0;
          end else if (w_cnt_inc == TMO_CYC) begin
            // Hold limit reached with the owner still active: force release.
            r_state  <= StIdle;
            r_gnt    <= 4'b0000;
            r_gnt_id <= 2'd0;
            r_busy   <= 1'b0;
            r_tmo    <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign TMO = r_tmo;
`else
  // Keeps the parameter referenced when the timeout option is compiled out.
  logic w_unused_tmo_cyc;
  assign w_unused_tmo_cyc = ^TMO_CYC;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state  <= StIdle;
      r_ptr    <= 2'd0;
      r_gnt    <= 4'b0000;
      r_gnt_id <= 2'd0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (|REQ) begin
            r_state  <= StGrant;
            r_gnt    <= 4'b0001 << w_pick;
            r_gnt_id <= w_pick;
            r_busy   <= 1'b1;
            r_ptr    <= w_pick + 2'd1;
          end
        end
        StGrant: begin
          if (w_release) begin
            r_state  <= StIdle;
            r_gnt    <= 4'b0000;
            r_gnt_id <= 2'd0;
            r_busy   <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign TMO = 1'b0;
`endif

  assign GNT    = r_gnt;
  assign GNT_ID = r_gnt_id;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_rr_arb4_2x.sv
module tb_rr_arb4_2x;

  localparam logic [3:0] TmoCyc = 4'd3;
`ifdef RR_ARB4_TMO_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic       CLK;
  logic       RSTB;
  logic [3:0] REQ;
  logic       DONE;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       BUSY;
  logic       TMO;

  int n_checks;
  int n_fail;

  // Reference model: owner index (-1 = nobody), next-priority requester,
  // number of completed grant cycles, and pending timeout pulse.
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_tmo;

  rr_arb4_2x #(
    .TMO_CYC(TmoCyc)
  ) dut (
    .CLK   (CLK),
    .RSTB  (RSTB),
    .REQ   (REQ),
    .DONE  (DONE),
    .GNT   (GNT),
    .GNT_ID(GNT_ID),
    .BUSY  (BUSY),
    .TMO   (TMO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_tmo   = 1'b0;
  endtask

  // One rising edge of the arbitration rules.
  task automatic model_edge(input logic [3:0] r, input logic d);
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      if (m_owner >= 0) begin
        m_ptr  = (m_owner + 1) % 4;
        m_held = 0;
      end
    end else begin
      m_held++;
      if (d || !r[m_owner]) begin
        m_owner = -1;
      end else if (TmoEn && m_held == int'(TmoCyc)) begin
        m_owner = -1;
        m_tmo   = 1'b1;
      end
    end
  endtask

  task automatic chk_model(input string tag);
    logic [3:0] eg;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk({tag, ".gnt"}, 32'(GNT), 32'(eg));
    chk({tag, ".id"}, 32'(GNT_ID), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk({tag, ".busy"}, 32'(BUSY), 32'(m_owner >= 0));
    chk({tag, ".tmo"}, 32'(TMO), 32'(m_tmo));
    chk({tag, ".onehot"}, 32'($countones(GNT) <= 1), 32'd1);
  endtask

  // Drive inputs away from the edge, apply one edge, then sample 1 ns later.
  task automatic cycle(input logic [3:0] r, input logic d, input string tag);
    REQ  = r;
    DONE = d;
    @(posedge CLK);
    model_edge(r, d);
    #1;
    chk_model(tag);
  endtask

  // Reset pulse placed mid-cycle; outputs must clear before any clock edge.
  task automatic mid_reset(input string tag);
    #2;
    RSTB = 1'b0;
    model_reset();
    #1;
    chk({tag, ".gnt"}, 32'(GNT), 32'd0);
    chk({tag, ".busy"}, 32'(BUSY), 32'd0);
    chk({tag, ".id"}, 32'(GNT_ID), 32'd0);
    chk({tag, ".tmo"}, 32'(TMO), 32'd0);
    #2;
    RSTB = 1'b1;
  endtask

  initial begin
    logic [3:0] seq [5];
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    RSTB = 1'b0;
    REQ  = 4'b0000;
    DONE = 1'b0;
    #12;
    chk_model("reset");
    RSTB = 1'b1;

    // Fair rotation with all requesters active and DONE two cycles after each grant.
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      cycle(4'b1111, 1'b0, "rot.grant");
      chk("rot.seq", 32'(GNT), 32'(seq[j]));
      cycle(4'b1111, 1'b0, "rot.hold");
      chk("rot.held", 32'(GNT), 32'(seq[j]));
      cycle(4'b1111, (j < 4), "rot.rel");
      if (j < 4) chk("rot.gap", 32'(GNT), 32'd0);
    end
    cycle(4'b1111, 1'b1, "rot.end");

    // Requester 3 alone, then pointer wrap back to requester 0.
    cycle(4'b1000, 1'b0, "r3.grant");
    chk("r3.gnt", 32'(GNT), 32'h8);
    chk("r3.id", 32'(GNT_ID), 32'd3);
    cycle(4'b1000, 1'b1, "r3.rel");
    cycle(4'b1001, 1'b0, "wrap.grant");
    chk("wrap.gnt", 32'(GNT), 32'h1);
    cycle(4'b1001, 1'b1, "wrap.rel");

    // Owner 1 drops its request; pointer must stay at 2.
    cycle(4'b0010, 1'b0, "drop.grant");
    chk("drop.gnt", 32'(GNT), 32'h2);
    cycle(4'b0000, 1'b0, "drop.rel");
    chk("drop.busy", 32'(BUSY), 32'd0);
    cycle(4'b1111, 1'b0, "ptr2.grant");
    chk("ptr2.gnt", 32'(GNT), 32'h4);

    // Asynchronous reset while requester 2 owns the grant.
    mid_reset("arst");
    cycle(4'b0110, 1'b0, "arst.grant");
    chk("arst.gnt", 32'(GNT), 32'h2);
    cycle(4'b0000, 1'b0, "arst.rel");

`ifdef RR_ARB4_TMO_EN
    cycle(4'b0001, 1'b0, "tmo.grant");
    for (int k = 0; k < 2; k++) begin
      cycle(4'b0001, 1'b0, "tmo.hold");
      chk("tmo.held", 32'(GNT), 32'h1);
    end
    cycle(4'b0001, 1'b0, "tmo.fire");
    chk("tmo.gnt", 32'(GNT), 32'h0);
    chk("tmo.pulse", 32'(TMO), 32'd1);
    cycle(4'b0000, 1'b0, "tmo.after");
    chk("tmo.clear", 32'(TMO), 32'd0);
    cycle(4'b0001, 1'b0, "tmod.grant");
    cycle(4'b0001, 1'b0, "tmod.hold");
    cycle(4'b0001, 1'b0, "tmod.hold");
    cycle(4'b0001, 1'b1, "tmod.done");
    chk("tmod.gnt", 32'(GNT), 32'h0);
    chk("tmod.tmo", 32'(TMO), 32'd0);
    cycle(4'b0000, 1'b0, "tmod.idle");
`else
    cycle(4'b0001, 1'b0, "hold.grant");
    for (int k = 0; k < 100; k++) begin
      cycle(4'b0001, 1'b0, "hold.cyc");
      chk("hold.gnt", 32'(GNT), 32'h1);
      chk("hold.tmo", 32'(TMO), 32'd0);
    end
    cycle(4'b0000, 1'b0, "hold.rel");
`endif

    // Random traffic against the model, with occasional mid-cycle resets.
    for (int k = 0; k < 400; k++) begin
      cycle(4'($urandom), ($urandom_range(0, 3) == 0), "rand");
      if ($urandom_range(0, 99) == 0) mid_reset("rand.rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
